// File: rtl/mc_maindec.sv
// ============================================================================
// Module   : mc_maindec
// Purpose  : Multicycle ARM main decoder: Moore FSM, ALU decoder, PC-write decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_maindec #(
    parameter int PC_REG  = 15,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               PCS,
    output logic               RegW,
    output logic               MemW,
    output logic [1:0]         FlagW,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = STATE_W'(0),
        S_DECODE  = STATE_W'(1),
        S_MEMADR  = STATE_W'(2),
        S_MEMRD   = STATE_W'(3),
        S_MEMWB   = STATE_W'(4),
        S_MEMWR   = STATE_W'(5),
        S_EXECR   = STATE_W'(6),
        S_EXECI   = STATE_W'(7),
        S_ALUWB   = STATE_W'(8),
        S_BRANCH  = STATE_W'(9),
        S_UNKNOWN = STATE_W'(10)
    } state_t;

    state_t r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        2'b00:   r_state <= Funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   r_state <= S_MEMADR;
                        2'b10:   r_state <= S_BRANCH;
                        default: r_state <= S_UNKNOWN;
                    endcase
                end
                S_MEMADR: r_state <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXECR,
                S_EXECI:  r_state <= S_ALUWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    logic       w_irwrite, w_nextpc, w_regw, w_memw, w_branch, w_aluop;
    logic       w_adrsrc, w_alusrca;
    logic [1:0] w_alusrcb, w_resultsrc;

    logic [3:0] w_cmd;
    logic       w_nowrite;

    assign w_cmd     = Funct[4:1];
    // IR is frozen from EXECx through ALUWB, so NoWrite needs no register.
    assign w_nowrite = (w_cmd == 4'b1010);

    always_comb begin
        w_irwrite   = 1'b0;
        w_nextpc    = 1'b0;
        w_regw      = 1'b0;
        w_memw      = 1'b0;
        w_branch    = 1'b0;
        w_aluop     = 1'b0;
        w_adrsrc    = 1'b0;
        w_alusrca   = 1'b0;
        w_alusrcb   = 2'b00;
        w_resultsrc = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_nextpc    = 1'b1;
                w_alusrca   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
            end
            S_DECODE: begin
                w_alusrca   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
            end
            S_MEMADR: w_alusrcb = 2'b01;
            S_MEMRD:  w_adrsrc  = 1'b1;
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regw      = 1'b1;
            end
            S_MEMWR: begin
                w_adrsrc = 1'b1;
                w_memw   = 1'b1;
            end
            S_EXECR:  w_aluop = 1'b1;
            S_EXECI: begin
                w_alusrcb = 2'b01;
                w_aluop   = 1'b1;
            end
            S_ALUWB:  w_regw = ~w_nowrite;
            S_BRANCH: begin
                w_alusrcb   = 2'b01;
                w_resultsrc = 2'b10;
                w_branch    = 1'b1;
            end
            default: ;
        endcase
    end

    logic [1:0] w_aluctl;
    logic       w_known, w_arith;

    always_comb begin
        w_aluctl = 2'b00;
        w_known  = 1'b1;
        w_arith  = 1'b0;
        case (w_cmd)
            4'b0100: begin w_aluctl = 2'b00; w_arith = 1'b1; end
            4'b0010: begin w_aluctl = 2'b01; w_arith = 1'b1; end
            4'b1010: begin w_aluctl = 2'b01; w_arith = 1'b1; end
            4'b0000: w_aluctl = 2'b10;
            4'b1100: w_aluctl = 2'b11;
            default: w_known  = 1'b0;
        endcase
    end

    logic [1:0] w_flagw;
    logic       w_pcs;

    assign w_flagw = (w_aluop & w_known) ? {Funct[0], Funct[0] & w_arith} : 2'b00;
    assign w_pcs   = w_branch | (w_regw & (Rd == 4'(PC_REG)));

    // Write strobes are killed combinationally so nothing fires while reset is low.
    assign IRWrite    = reset & w_irwrite;
    assign NextPC     = reset & w_nextpc;
    assign PCS        = reset & w_pcs;
    assign RegW       = reset & w_regw;
    assign MemW       = reset & w_memw;
    assign FlagW      = reset ? w_flagw : 2'b00;

    assign AdrSrc     = w_adrsrc;
    assign ALUSrcA    = w_alusrca;
    assign ALUSrcB    = w_alusrcb;
    assign ResultSrc  = w_resultsrc;
    assign ALUControl = w_aluop ? w_aluctl : 2'b00;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};
    assign State      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_maindec.sv
// ============================================================================
// Module   : tb_mc_maindec
// Purpose  : Directed table-driven bench for mc_maindec.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_maindec;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, NextPC, PCS, RegW, MemW, AdrSrc, ALUSrcA;
    logic [1:0] FlagW, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    mc_maindec #(.PC_REG(15), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .IRWrite(IRWrite), .NextPC(NextPC), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .FlagW(FlagW), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stb = {IRWrite, NextPC, PCS, RegW, MemW}
    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] st;
        logic [4:0] stb;
        logic [1:0] flagw;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] aluc;
    } vec_t;

    vec_t tbl [0:39];
    int   n = 0;

    task automatic add(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                       input logic [3:0] st, input logic [4:0] stb, input logic [1:0] flagw,
                       input logic adr, input logic srca, input logic [1:0] srcb,
                       input logic [1:0] res, input logic [1:0] aluc);
        tbl[n] = '{op, funct, rd, st, stb, flagw, adr, srca, srcb, res, aluc};
        n++;
    endtask

    task automatic check(input string name, input vec_t v);
        logic [27:0] got, exp;
        logic [1:0]  rsrc;
        rsrc = {v.op == 2'b01, v.op == 2'b10};
        got = {State, IRWrite, NextPC, PCS, RegW, MemW, FlagW, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};
        exp = {v.st, v.stb, v.flagw, v.adr, v.srca, v.srcb, v.res, v.aluc, v.op, rsrc};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h required=%h (st/irw,npc,pcs,regw,memw/flagw/adr/srca/srcb/res/aluc/imm/regsrc)",
                     name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        Op    = v.op;
        Funct = v.funct;
        Rd    = v.rd;
    endtask

    vec_t rv;
    bit   found;

    initial begin
        reset = 1'b0;
        Op    = 2'b00;
        Funct = 6'b000000;
        Rd    = 4'd0;

        // FETCH decode with all strobes suppressed while reset is low
        rv = '{2'b00, 6'b0, 4'd0, 4'd0, 5'b00000, 2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("reset_hold%0d", i), rv);
        end

        // ADDS R1, imm
        add(2'b00, 6'b101001, 4'd1, 4'd0, 5'b11000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b00, 6'b101001, 4'd1, 4'd1, 5'b00000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b00, 6'b101001, 4'd1, 4'd7, 5'b00000, 2'b11, 0, 0, 2'b01, 2'b00, 2'b00);
        add(2'b00, 6'b101001, 4'd1, 4'd8, 5'b00010, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00);
        // LDR R15
        add(2'b01, 6'b011001, 4'd15, 4'd0, 5'b11000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b01, 6'b011001, 4'd15, 4'd1, 5'b00000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b01, 6'b011001, 4'd15, 4'd2, 5'b00000, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00);
        add(2'b01, 6'b011001, 4'd15, 4'd3, 5'b00000, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00);
        add(2'b01, 6'b011001, 4'd15, 4'd4, 5'b00110, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00);
        // STR
        add(2'b01, 6'b011000, 4'd2, 4'd0, 5'b11000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b01, 6'b011000, 4'd2, 4'd1, 5'b00000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b01, 6'b011000, 4'd2, 4'd2, 5'b00000, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00);
        add(2'b01, 6'b011000, 4'd2, 4'd5, 5'b00001, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00);
        // CMP register
        add(2'b00, 6'b010101, 4'd0, 4'd0, 5'b11000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b00, 6'b010101, 4'd0, 4'd1, 5'b00000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b00, 6'b010101, 4'd0, 4'd6, 5'b00000, 2'b11, 0, 0, 2'b00, 2'b00, 2'b01);
        add(2'b00, 6'b010101, 4'd0, 4'd8, 5'b00000, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00);
        // ORR R15, register, no S: writes PC through ALUWB
        add(2'b00, 6'b011000, 4'd15, 4'd0, 5'b11000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b00, 6'b011000, 4'd15, 4'd1, 5'b00000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b00, 6'b011000, 4'd15, 4'd6, 5'b00000, 2'b00, 0, 0, 2'b00, 2'b00, 2'b11);
        add(2'b00, 6'b011000, 4'd15, 4'd8, 5'b00110, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00);
        // ANDS R3, imm: logical op updates NZ only
        add(2'b00, 6'b100001, 4'd3, 4'd0, 5'b11000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b00, 6'b100001, 4'd3, 4'd1, 5'b00000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b00, 6'b100001, 4'd3, 4'd7, 5'b00000, 2'b10, 0, 0, 2'b01, 2'b00, 2'b10);
        add(2'b00, 6'b100001, 4'd3, 4'd8, 5'b00010, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00);
        // B
        add(2'b10, 6'b000000, 4'd0, 4'd0, 5'b11000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b10, 6'b000000, 4'd0, 4'd1, 5'b00000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b10, 6'b000000, 4'd0, 4'd9, 5'b00100, 2'b00, 0, 0, 2'b01, 2'b10, 2'b00);
        // Op=11 with an S-bit ADD pattern: no strobe may leak out
        add(2'b11, 6'b001001, 4'd15, 4'd0, 5'b11000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b11, 6'b001001, 4'd15, 4'd1, 5'b00000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);
        add(2'b11, 6'b001001, 4'd15, 4'd10, 5'b00000, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00);
        add(2'b00, 6'b000000, 4'd0, 4'd0, 5'b11000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            apply(tbl[i]);
            #1;
            check($sformatf("vec%0d", i), tbl[i]);
            @(negedge clk);
        end

        // STR aborted by reset while in MEMWR
        rv = '{2'b01, 6'b011000, 4'd15, 4'd0, 5'b00000, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00};
        apply(rv);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            if (State == 4'd5) found = 1;
            else @(negedge clk);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reach_memwr: got=%0d required=5", State);
        end
        total++;
        if (MemW !== 1'b1) begin
            bad++;
            $display("FAIL memwr_memw: got=%b required=1", MemW);
        end
        reset = 1'b0;
        #1;
        check("abort_now", rv);
        @(negedge clk);
        #1;
        check("abort_hold", rv);
        reset = 1'b1;
        #1;
        rv.stb = 5'b11000;
        check("abort_release", rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
